// File: rtl/tcm_arb_pkg.sv
// tcm_arb_pkg: shared types and defaults for the TCM port arbiter.
//   state_e       : response-phase state (IDLE, RSP_I, RSP_D)
//   gnt_e         : which port owns the RAM this cycle (GNT_I, GNT_D)
//   TCM_*         : default BASE_ADDR / RAM_AW / STARVE_MAX values
//   addr_in_range : true when a byte address falls inside the TCM window
package tcm_arb_pkg;

  localparam logic [31:0] TCM_BASE_ADDR  = 32'h8000_0000;
  localparam int unsigned TCM_RAM_AW     = 14;
  localparam int unsigned TCM_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    RSP_I,
    RSP_D
  } state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_e;

  // Window is [base, base + 2^(aw+3)) in bytes.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned aw);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> (aw + 3)) == 32'd0);
  endfunction

endpackage

// File: rtl/tcm_arb_sel.sv
// tcm_arb_sel: combinational grant selection for the fetch (I) and data (D)
// ports, plus the history state that decides contended cycles.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   req_i_i        : fetch request present
//   req_d_i        : data request present
//   gnt_valid_o    : a port is granted this cycle
//   gnt_o          : which port is granted
// Build option TCM_ARB_ROUND_ROBIN_EN: contended cycles alternate based on
// the last grant. Default: data wins, fetch wins after STARVE_MAX losses.
module tcm_arb_sel
  import tcm_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = TCM_STARVE_MAX
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_i_i,
  input  logic req_d_i,
  output logic gnt_valid_o,
  output gnt_e gnt_o
);

  gnt_e contend_win;

`ifdef TCM_ARB_ROUND_ROBIN_EN
  gnt_e last_q;

  assign contend_win = (last_q == GNT_I) ? GNT_D : GNT_I;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_q <= GNT_I;
    end else if (gnt_valid_o) begin
      last_q <= gnt_o;
    end
  end
`else
  localparam int unsigned CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0] starve_q;

  assign contend_win = (starve_q >= CW'(STARVE_MAX)) ? GNT_I : GNT_D;

  // A data grant while fetch is requesting is a contended fetch loss.
  // The counter cannot pass STARVE_MAX since fetch then wins and clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      starve_q <= '0;
    end else if (gnt_valid_o && gnt_o == GNT_I) begin
      starve_q <= '0;
    end else if (gnt_valid_o && req_i_i) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`endif

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_o       = GNT_I;
    if (rst_n_i) begin
      if (req_i_i && req_d_i) begin
        gnt_valid_o = 1'b1;
        gnt_o       = contend_win;
      end else if (req_i_i) begin
        gnt_valid_o = 1'b1;
        gnt_o       = GNT_I;
      end else if (req_d_i) begin
        gnt_valid_o = 1'b1;
        gnt_o       = GNT_D;
      end
    end
  end

endmodule

// File: rtl/tcm_port_arbiter.sv
// tcm_port_arbiter: shares one single-port 64-bit TCM RAM between an
// instruction-fetch port and a 32-bit data port, one grant per cycle,
// responses exactly one cycle after accept.
//   clk, rst_n          : clock, synchronous active-low reset
//   mem_i_*             : fetch port (rd/pc in, accept/valid/inst/error out)
//   mem_d_*             : data port (rd/wr/addr/data/tag in,
//                         accept/ack/data/tag/error out)
//   ram_*               : RAM side (en/we/addr/wdata out, rdata in)
// Build option TCM_ARB_ROUND_ROBIN_EN selects round-robin contention
// handling (see tcm_arb_sel).
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = TCM_BASE_ADDR,
  parameter int unsigned RAM_AW     = TCM_RAM_AW,
  parameter int unsigned STARVE_MAX = TCM_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_i_rd_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic [63:0]       mem_i_inst_o,
  output logic              mem_i_error_o,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic [10:0]       mem_d_req_tag_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [10:0]       mem_d_resp_tag_o,
  output logic              mem_d_error_o,
  output logic              ram_en_o,
  output logic [7:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [63:0]       ram_wdata_o,
  input  logic [63:0]       ram_rdata_i
);

  logic   req_d, d_write, i_in, d_in;
  logic   gnt_valid, gnt_i, gnt_d;
  gnt_e   gnt;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        lane_q, lane_d;
  logic [10:0] tag_q, tag_d;
  logic [63:0] inst_q;
  logic [31:0] data_q;
  logic        rsp_i, rsp_d;
  logic [31:0] lane_rdata;

  assign d_write = |mem_d_wr_i;
  assign req_d   = mem_d_rd_i | d_write;
  assign i_in    = addr_in_range(mem_i_pc_i, BASE_ADDR, RAM_AW);
  assign d_in    = addr_in_range(mem_d_addr_i, BASE_ADDR, RAM_AW);

  tcm_arb_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i_i    (mem_i_rd_i),
    .req_d_i    (req_d),
    .gnt_valid_o(gnt_valid),
    .gnt_o      (gnt)
  );

  assign gnt_i          = gnt_valid && gnt == GNT_I;
  assign gnt_d          = gnt_valid && gnt == GNT_D;
  assign mem_i_accept_o = gnt_i;
  assign mem_d_accept_o = gnt_d;

  // RAM request side
  assign ram_en_o    = (gnt_i && i_in) || (gnt_d && d_in);
  assign ram_addr_o  = gnt_i ? mem_i_pc_i[RAM_AW+2:3] : mem_d_addr_i[RAM_AW+2:3];
  assign ram_wdata_o = {mem_d_data_wr_i, mem_d_data_wr_i};

  always_comb begin
    ram_we_o = '0;
    if (gnt_d && d_in && d_write) begin
      ram_we_o = mem_d_addr_i[2] ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
    end
  end

  // Response-phase next state: follows the grant every cycle
  always_comb begin
    state_d = IDLE;
    err_d   = 1'b0;
    lane_d  = lane_q;
    tag_d   = tag_q;
    if (gnt_i) begin
      state_d = RSP_I;
      err_d   = !i_in;
    end else if (gnt_d) begin
      state_d = RSP_D;
      err_d   = !d_in;
      lane_d  = mem_d_addr_i[2];
      tag_d   = mem_d_req_tag_i;
    end
  end

  // Qualifying with rst_n drops a response that is pending as reset asserts.
  assign rsp_i      = rst_n && state_q == RSP_I;
  assign rsp_d      = rst_n && state_q == RSP_D;
  assign lane_rdata = lane_q ? ram_rdata_i[63:32] : ram_rdata_i[31:0];

  assign mem_i_valid_o    = rsp_i;
  assign mem_i_error_o    = rsp_i && err_q;
  assign mem_d_ack_o      = rsp_d;
  assign mem_d_error_o    = rsp_d && err_q;
  assign mem_d_resp_tag_o = tag_q;

  // RAM data only exists in the response cycle; the holding registers
  // keep the last delivered value visible afterwards.
  assign mem_i_inst_o    = rsp_i ? (err_q ? '0 : ram_rdata_i) : inst_q;
  assign mem_d_data_rd_o = rsp_d ? (err_q ? '0 : lane_rdata)  : data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      lane_q  <= 1'b0;
      tag_q   <= '0;
      inst_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      lane_q  <= lane_d;
      tag_q   <= tag_d;
      if (rsp_i) inst_q <= mem_i_inst_o;
      if (rsp_d) data_q <= mem_d_data_rd_o;
    end
  end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// tb_tcm_port_arbiter: directed self-checking bench for tcm_port_arbiter
// with a small behavioural RAM (one-cycle read latency, byte writes).
module tb_tcm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_i_rd_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [63:0] mem_i_inst_o;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0] mem_d_data_rd_o;
  logic [10:0] mem_d_resp_tag_o;
  logic        ram_en_o;
  logic [7:0]  ram_we_o;
  logic [13:0] ram_addr_o;
  logic [63:0] ram_wdata_o;
  logic [63:0] ram_rdata_i;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  tcm_port_arbiter #(
    .BASE_ADDR (32'h8000_0000),
    .RAM_AW    (14),
    .STARVE_MAX(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_i_rd_i      (mem_i_rd_i),
    .mem_i_pc_i      (mem_i_pc_i),
    .mem_i_accept_o  (mem_i_accept_o),
    .mem_i_valid_o   (mem_i_valid_o),
    .mem_i_inst_o    (mem_i_inst_o),
    .mem_i_error_o   (mem_i_error_o),
    .mem_d_rd_i      (mem_d_rd_i),
    .mem_d_wr_i      (mem_d_wr_i),
    .mem_d_addr_i    (mem_d_addr_i),
    .mem_d_data_wr_i (mem_d_data_wr_i),
    .mem_d_req_tag_i (mem_d_req_tag_i),
    .mem_d_accept_o  (mem_d_accept_o),
    .mem_d_ack_o     (mem_d_ack_o),
    .mem_d_data_rd_o (mem_d_data_rd_o),
    .mem_d_resp_tag_o(mem_d_resp_tag_o),
    .mem_d_error_o   (mem_d_error_o),
    .ram_en_o        (ram_en_o),
    .ram_we_o        (ram_we_o),
    .ram_addr_o      (ram_addr_o),
    .ram_wdata_o     (ram_wdata_o),
    .ram_rdata_i     (ram_rdata_i)
  );

  // Behavioural RAM: 16 words, read-before-write, one-cycle latency.
  logic [63:0] ram [16];
  logic        preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= 64'h0;
      ram[1] <= 64'h1111_2222_3333_4444;
    end else if (ram_en_o) begin
      ram_rdata_i <= ram[ram_addr_o[3:0]];
      for (int b = 0; b < 8; b++) begin
        if (ram_we_o[b]) ram[ram_addr_o[3:0]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_i_rd_i      = 1'b0;
    mem_i_pc_i      = 32'h0;
    mem_d_rd_i      = 1'b0;
    mem_d_wr_i      = 4'h0;
    mem_d_addr_i    = 32'h0;
    mem_d_data_wr_i = 32'h0;
    mem_d_req_tag_i = 11'h0;
  endtask

  logic [8:0] exp_gi;
  logic       prev_gi;

  initial begin
`ifdef TCM_ARB_ROUND_ROBIN_EN
    exp_gi = 9'b1_0101_0101;
`else
    exp_gi = 9'b0_0001_0000;
`endif
    rst_n   = 1'b0;
    preload = 1'b1;
    ram_rdata_i = 64'h0;
    idle_inputs();

    // Reset state
    cyc(); cyc();
    #1;
    check("rst_acc_i", mem_i_accept_o, 0);
    check("rst_acc_d", mem_d_accept_o, 0);
    check("rst_valid", mem_i_valid_o, 0);
    check("rst_ack",   mem_d_ack_o, 0);
    check("rst_en_we", {ram_en_o, ram_we_o}, 0);
    check("rst_outs",  {mem_i_inst_o, mem_d_data_rd_o, mem_d_resp_tag_o}, 0);
    cyc();
    rst_n = 1'b1; preload = 1'b0;

    // Fetch of RAM word 1
    cyc();
    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h8000_0008;
    #1;
    check("f_acc",  mem_i_accept_o, 1);
    check("f_en",   ram_en_o, 1);
    check("f_addr", ram_addr_o, 1);
    check("f_we",   ram_we_o, 0);
    cyc();
    idle_inputs();
    #1;
    check("f_valid", mem_i_valid_o, 1);
    check("f_inst",  mem_i_inst_o, 64'h1111_2222_3333_4444);
    check("f_err",   mem_i_error_o, 0);
    cyc();
    #1;
    check("f_valid_drop", mem_i_valid_o, 0);
    check("f_inst_hold",  mem_i_inst_o, 64'h1111_2222_3333_4444);

    // Upper-lane write followed back-to-back by a read of the same word
    mem_d_wr_i = 4'b0011; mem_d_addr_i = 32'h8000_0004;
    mem_d_data_wr_i = 32'hAABB_CCDD; mem_d_req_tag_i = 11'h5;
    #1;
    check("w_acc",   mem_d_accept_o, 1);
    check("w_we",    ram_we_o, 8'h30);
    check("w_wdata", ram_wdata_o, 64'hAABB_CCDD_AABB_CCDD);
    check("w_addr",  ram_addr_o, 0);
    cyc();
    idle_inputs();
    mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h8000_0004; mem_d_req_tag_i = 11'h7;
    #1;
    check("w_ack",  mem_d_ack_o, 1);
    check("w_tag",  mem_d_resp_tag_o, 11'h5);
    check("r_acc",  mem_d_accept_o, 1);
    check("r_we",   ram_we_o, 0);
    check("r_en",   ram_en_o, 1);
    cyc();
    idle_inputs();
    #1;
    check("r_ack",  mem_d_ack_o, 1);
    check("r_data", mem_d_data_rd_o, 32'h0000_CCDD);
    check("r_tag",  mem_d_resp_tag_o, 11'h7);
    check("r_err",  mem_d_error_o, 0);

    // Continuous contention
    prev_gi = 1'b0;
    for (int c = 0; c < 9; c++) begin
      cyc();
      mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h8000_0008;
      mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h8000_0000;
      #1;
      check($sformatf("cont_i%0d", c), mem_i_accept_o, exp_gi[c]);
      check($sformatf("cont_d%0d", c), mem_d_accept_o, !exp_gi[c]);
      if (c > 0) check($sformatf("cont_v%0d", c), mem_i_valid_o, prev_gi);
      prev_gi = exp_gi[c];
    end
    cyc();
    idle_inputs();
    cyc();

    // Out-of-range data read and fetch just past the window
    mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h0000_1000; mem_d_req_tag_i = 11'h9;
    #1;
    check("oor_d_acc", mem_d_accept_o, 1);
    check("oor_d_en",  ram_en_o, 0);
    cyc();
    idle_inputs();
    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h8002_0000;
    #1;
    check("oor_d_ack",  mem_d_ack_o, 1);
    check("oor_d_err",  mem_d_error_o, 1);
    check("oor_d_data", mem_d_data_rd_o, 0);
    check("oor_d_tag",  mem_d_resp_tag_o, 11'h9);
    check("oor_i_acc",  mem_i_accept_o, 1);
    check("oor_i_en",   ram_en_o, 0);
    cyc();
    idle_inputs();
    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h8001_FFF8;
    #1;
    check("oor_i_valid", mem_i_valid_o, 1);
    check("oor_i_err",   mem_i_error_o, 1);
    check("oor_i_inst",  mem_i_inst_o, 0);
    check("last_in_en",  ram_en_o, 1);
    check("oor_d_clr",   {mem_d_ack_o, mem_d_error_o}, 0);
    cyc();
    idle_inputs();
    #1;
    check("last_in_err", {mem_i_valid_o, mem_i_error_o}, 2'b10);
    cyc();

    // Reset asserted the cycle after a fetch accept
    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h8000_0008;
    #1;
    check("rs_acc", mem_i_accept_o, 1);
    cyc();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rs_no_valid", mem_i_valid_o, 0);
    cyc();
    #1;
    check("rs_outs", {mem_i_valid_o, mem_i_error_o, mem_d_ack_o, mem_d_error_o,
                      ram_en_o, ram_we_o}, 0);
    check("rs_data", {mem_i_inst_o, mem_d_data_rd_o, mem_d_resp_tag_o}, 0);
    rst_n = 1'b1;
    cyc();
    #1;
    check("rs_rel_valid", mem_i_valid_o, 0);
    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h8000_0008;
    mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h8000_0000;
    #1;
    check("rs_cont_d", mem_d_accept_o, 1);
    check("rs_cont_i", mem_i_accept_o, 0);
    cyc();
    idle_inputs();
    #1;
    check("rs_cont_ack", mem_d_ack_o, 1);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
